// File: rtl/program_loader_pkg.sv
// Shared types and helpers for the program loader.
// The optional CHECK state exists only when PROGRAM_LOADER_CHECKSUM_EN is defined.
package program_loader_pkg;

    localparam logic [31:0] DEFAULT_END_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_DONE,
        ST_ERROR
    } state_e;

    // Word counter must be able to hold the full depth, not just depth-1.
    function automatic int word_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Shifts NB_BYTE symbols MSB-first into a LEN-bit word and flags the byte that completes it.
// o_word/o_word_valid are combinational so the consumer can register the finished word directly.
module byte_assembler #(
    parameter int LEN     = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic [NB_BYTE-1:0] i_data,
    input  logic               i_valid,
    output logic [LEN-1:0]     o_word,
    output logic               o_word_valid
);

    localparam int NBYTES = LEN / NB_BYTE;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN-1:0]   shift_q, shift_d;
    logic             take;

    always_comb begin
        take         = i_en && i_valid && !i_clr;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        o_word_valid = 1'b0;
        if (i_clr) begin
            cnt_d = '0;
        end else if (take) begin
            shift_d = (shift_q << NB_BYTE) | LEN'(i_data);
            if (cnt_q == LAST) begin
                cnt_d        = '0;
                o_word_valid = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_word = shift_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Stale shift contents are always fully overwritten before the next word completes.
    always_ff @(posedge i_clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: rtl/program_loader.sv
// Streams bytes into instruction words and writes them through the core's preload port.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the sentinel.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int             LEN               = 32,
    parameter int             NB_BYTE           = 8,
    parameter int             RAM_DEPTH_PROGRAM = 32,
    parameter logic [LEN-1:0] END_WORD          = LEN'(DEFAULT_END_WORD)
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic                                          i_load_req,
    input  logic [NB_BYTE-1:0]                            i_rx_data,
    input  logic                                          i_rx_valid,
    output logic                                          o_preload_flag,
    output logic [LEN-1:0]                                o_preload_address,
    output logic [LEN-1:0]                                o_preload_instruction,
    output logic                                          o_cpu_rst,
    output logic                                          o_done,
    output logic                                          o_error,
    output logic [word_count_w(RAM_DEPTH_PROGRAM)-1:0]    o_word_count
);

    localparam int CW = word_count_w(RAM_DEPTH_PROGRAM);
    localparam logic [CW-1:0] DEPTH = CW'(RAM_DEPTH_PROGRAM);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_e AFTER_END = ST_CHECK;
`else
    localparam state_e AFTER_END = ST_DONE;
`endif

    state_e         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  addr_q, addr_d;
    logic           flag_q, flag_d;
    logic [LEN-1:0] instr_q, instr_d;
    logic           asm_clr, asm_en, word_valid;
    logic [LEN-1:0] word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0] csum_q, csum_d;
`endif

    assign asm_en  = (state_q == ST_LOAD);
    assign asm_clr = (state_q == ST_IDLE) ||
                     (i_load_req && state_q != ST_DONE && state_q != ST_ERROR);

    byte_assembler #(
        .LEN     (LEN),
        .NB_BYTE (NB_BYTE)
    ) u_byte_assembler (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clr        (asm_clr),
        .i_en         (asm_en),
        .i_data       (i_rx_data),
        .i_valid      (i_rx_valid),
        .o_word       (word),
        .o_word_valid (word_valid)
    );

    // count_q is both words-written and next write address; addr_q trails it by one
    // cycle so the address holds during the strobe and advances right after it.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = count_q;
        flag_d  = 1'b0;
        instr_d = instr_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                state_d = ST_LOAD;
                count_d = '0;
                addr_d  = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                csum_d  = '0;
`endif
            end
            ST_LOAD: begin
                if (i_load_req) begin
                    count_d = '0;
                    addr_d  = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    if (i_rx_valid) csum_d = csum_q ^ i_rx_data;
`endif
                    if (word_valid) begin
                        if (count_q < DEPTH) begin
                            flag_d  = 1'b1;
                            instr_d = word;
                            count_d = count_q + CW'(1);
                            if (word == END_WORD) state_d = AFTER_END;
                        end else begin
                            state_d = (word == END_WORD) ? AFTER_END : ST_ERROR;
                        end
                    end
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (i_load_req) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    addr_d  = '0;
                    csum_d  = '0;
                end else if (i_rx_valid) begin
                    state_d = (i_rx_data == csum_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            ST_DONE, ST_ERROR: begin
                if (i_load_req) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    addr_d  = '0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_LOAD;
            count_q <= '0;
            addr_q  <= '0;
            flag_q  <= 1'b0;
            instr_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            flag_q  <= flag_d;
            instr_q <= instr_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign o_preload_flag        = flag_q;
    assign o_preload_address     = LEN'(addr_q);
    assign o_preload_instruction = instr_q;
    assign o_cpu_rst             = (state_q != ST_DONE);
    assign o_done                = (state_q == ST_DONE);
    assign o_error               = (state_q == ST_ERROR);
    assign o_word_count          = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader with a stream-level reference model.
module tb_program_loader;

    localparam int LEN   = 32;
    localparam int NB    = 8;
    localparam int DEPTH = 32;
    localparam int CW    = 6;
    localparam logic [31:0] ENDW = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst, load_req, rx_valid;
    logic [7:0]    rx_data;
    logic          flag, cpu_rst, done, error;
    logic [31:0]   addr, instr;
    logic [CW-1:0] wcount;

    program_loader #(
        .LEN               (LEN),
        .NB_BYTE           (NB),
        .RAM_DEPTH_PROGRAM (DEPTH),
        .END_WORD          (ENDW)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_load_req            (load_req),
        .i_rx_data             (rx_data),
        .i_rx_valid            (rx_valid),
        .o_preload_flag        (flag),
        .o_preload_address     (addr),
        .o_preload_instruction (instr),
        .o_cpu_rst             (cpu_rst),
        .o_done                (done),
        .o_error               (error),
        .o_word_count          (wcount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: expected writes of the current session, derived from the byte stream.
    logic [7:0]  sq[$];
    logic [31:0] ew_addr[64];
    logic [31:0] ew_data[64];
    int          ew_last[64];
    int          n_ew, term_idx, term_kind, final_count;
    int          byte_cyc[512];
    int          n_driven, wr_ptr, n_strobes;
    bit          exp_done, exp_error, started;
    logic [31:0] first_addr, first_data, last_addr, last_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void clear_model();
        n_ew = 0; term_idx = -1; term_kind = 0; final_count = 0;
        n_driven = 0; wr_ptr = 0; n_strobes = 0;
        exp_done = 1'b0; exp_error = 1'b0;
    endfunction

    function automatic void predict();
        int a = 0;
        bit wait_ck = 1'b0;
        logic [7:0] x = 8'h00;
        logic [31:0] w;
        for (int i = 0; i < sq.size(); i++) begin
            if (term_idx >= 0) break;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (wait_ck) begin
                term_idx = i; term_kind = (sq[i] == x) ? 1 : 2;
                break;
            end
`endif
            x ^= sq[i];
            if (i % 4 == 3) begin
                w = {sq[i-3], sq[i-2], sq[i-1], sq[i]};
                if (a < DEPTH) begin
                    ew_addr[n_ew] = a; ew_data[n_ew] = w; ew_last[n_ew] = i;
                    n_ew++; a++;
                    if (w == ENDW) wait_ck = 1'b1;
                end else begin
                    if (w == ENDW) wait_ck = 1'b1;
                    else begin term_idx = i; term_kind = 2; end
                end
`ifndef PROGRAM_LOADER_CHECKSUM_EN
                if (wait_ck) begin term_idx = i; term_kind = 1; end
`endif
            end
        end
        final_count = a;
    endfunction

    // Compare process: every cycle after the first reset.
    always @(negedge clk) begin
        bit due;
        if (started) begin
            due = (wr_ptr < n_ew) && (ew_last[wr_ptr] < n_driven) &&
                  (cyc == byte_cyc[ew_last[wr_ptr]] + 1);
            chk("strobe", flag, due);
            if (due) begin
                if (flag) begin
                    chk("wr_addr", addr, ew_addr[wr_ptr]);
                    chk("wr_data", instr, ew_data[wr_ptr]);
                end
                wr_ptr++;
            end
            if (flag) begin
                if (n_strobes == 0) begin first_addr = addr; first_data = instr; end
                last_addr = addr; last_data = instr;
                n_strobes++;
            end
            if (term_idx >= 0 && term_idx < n_driven && cyc == byte_cyc[term_idx] + 1) begin
                exp_done  = (term_kind == 1);
                exp_error = (term_kind == 2);
            end
            chk("word_count", wcount, wr_ptr);
            chk("done", done, exp_done);
            chk("error", error, exp_error);
            chk("cpu_rst", cpu_rst, !exp_done);
        end
    end

    task automatic do_reset();
        rst = 1'b1; rx_valid = 1'b0; load_req = 1'b0;
        @(posedge clk); #1;
        clear_model();
        started = 1'b1;
        rst = 1'b0;
        chk("rst_flag", flag, 0);
        chk("rst_addr", addr, 0);
        chk("rst_instr", instr, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_count", wcount, 0);
    endtask

    task automatic do_load_req();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        clear_model();
        chk("req_done_low", done, 0);
        @(posedge clk); #1;
    endtask

    // gap_mode: 0 none, 1 random 0..2 idle cycles, 2 two idle cycles before each byte
    task automatic drive(input int gap_mode);
        int g;
        predict();
        for (int i = 0; i < sq.size(); i++) begin
            g = (gap_mode == 0) ? 0 : (gap_mode == 2) ? 2 : $urandom_range(0, 2);
            if (i == 0) g = 0;
            repeat (g) begin rx_valid = 1'b0; @(posedge clk); #1; end
            rx_valid = 1'b1; rx_data = sq[i];
            byte_cyc[n_driven] = cyc;
            n_driven++;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (4) begin @(posedge clk); #1; end
        chk("strobe_total", n_strobes, n_ew);
        chk("final_count", wcount, final_count);
    endtask

    task automatic push_word(input logic [31:0] w);
        sq.push_back(w[31:24]); sq.push_back(w[23:16]);
        sq.push_back(w[15:8]);  sq.push_back(w[7:0]);
    endtask

    task automatic push_end();
        logic [7:0] x;
        push_word(ENDW);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        x = 8'h00;
        foreach (sq[i]) x ^= sq[i];
        sq.push_back(x);
`endif
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w == ENDW) w = 32'h0;
        return w;
    endfunction

    initial begin
        rst = 1'b1; load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; started = 1'b0;
        clear_model();
        #1;
        do_reset();

        // Basic program: one instruction plus sentinel
        sq = {8'h8C, 8'h01, 8'h00, 8'h04};
        push_end();
        drive(0);
        chk("model_w0", ew_data[0], 32'h8C01_0004);
        chk("model_n", n_ew, 2);
        settle();
        chk("t1_done", done, 1);
        chk("t1_cpu_rst", cpu_rst, 0);
        chk("t1_count", wcount, 2);
        chk("t1_first", first_data, 32'h8C01_0004);
        chk("t1_last_addr", last_addr, 1);
        chk("t1_last_data", last_data, 32'hFFFF_FFFF);

        // Same stream with idle gaps between bytes
        do_load_req();
        sq = {8'h8C, 8'h01, 8'h00, 8'h04};
        push_end();
        drive(2);
        settle();
        chk("t2_done", done, 1);
        chk("t2_first", first_data, 32'h8C01_0004);

        // Overflow: 33 ordinary words into a 32-word memory
        do_load_req();
        sq.delete();
        repeat (33) push_word(rnd_word());
        drive(1);
        chk("model_ovf_n", n_ew, 32);
        settle();
        chk("t3_error", error, 1);
        chk("t3_cpu_rst", cpu_rst, 1);
        chk("t3_count", wcount, 32);
        chk("t3_last_addr", last_addr, 31);

        // Reset in the middle of a word
        do_reset();
        sq = {8'hAA, 8'hBB};
        drive(0);
        do_reset();
        sq = {8'h11, 8'h22, 8'h33, 8'h44};
        push_end();
        drive(0);
        settle();
        chk("t4_first_addr", first_addr, 0);
        chk("t4_first_data", first_data, 32'h1122_3344);

        // Reload from DONE
        do_load_req();
        sq.delete();
        push_word(32'h2008_0005);
        push_end();
        drive(1);
        settle();
        chk("t5_done", done, 1);
        chk("t5_first_addr", first_addr, 0);
        chk("t5_count", wcount, 2);

        // Program fills memory exactly; sentinel lands past the end
        do_load_req();
        sq.delete();
        repeat (32) push_word(rnd_word());
        push_end();
        drive(0);
        chk("model_fill_n", n_ew, 32);
        settle();
        chk("t6_done", done, 1);
        chk("t6_count", wcount, 32);

        // Restart while still loading
        do_load_req();
        sq.delete();
        repeat (3) push_word(rnd_word());
        drive(1);
        settle();
        do_load_req();
        sq.delete();
        push_word(32'hDEAD_BEEF);
        push_end();
        drive(1);
        settle();
        chk("t7_first_addr", first_addr, 0);
        chk("t7_done", done, 1);

        // Randomized sessions
        for (int s = 0; s < 12; s++) begin
            if ($urandom_range(0, 2) == 0) do_reset();
            else do_load_req();
            sq.delete();
            repeat ($urandom_range(0, 35)) push_word(rnd_word());
            if ($urandom_range(0, 9) < 7) begin
                push_end();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if ($urandom_range(0, 1) == 1) sq[sq.size()-1] = sq[sq.size()-1] ^ 8'h01;
`endif
            end
            if ($urandom_range(0, 3) == 0) sq.push_back(8'($urandom));
            drive(1);
            settle();
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Checksum byte 00 on a zero-XOR stream, then the same stream with 5A
        do_load_req();
        sq.delete();
        push_word(32'h1212_1212);
        push_word(ENDW);
        sq.push_back(8'h00);
        drive(0);
        settle();
        chk("ck_ok_done", done, 1);
        do_load_req();
        sq.delete();
        push_word(32'h1212_1212);
        push_word(ENDW);
        sq.push_back(8'h5A);
        drive(0);
        settle();
        chk("ck_bad_error", error, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Synthesisable replacement for bench-driven instruction preload. Receives a byte stream (typically from the UART receiver), assembles bytes into instruction words of parametrised width, and writes them sequentially into program memory through the existing preload port of the MIPS core. It holds the core in reset while loading and releases it once the end-of-program word is written. It also supports reload on request and reports address overflow.

## Interface
Parameters:
- `LEN`, 32: instruction word width; must be a multiple of `NB_BYTE`.
- `NB_BYTE`, 8: input stream symbol width.
- `RAM_DEPTH_PROGRAM`, 32: program memory depth in words.
- `END_WORD`, 32'hFFFFFFFF: end-of-program sentinel, `LEN` bits.

Ports (one clock; reset is synchronous and active-high):
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous active-high reset.
- `i_load_req` in 1: single-cycle request to (re)start loading.
- `i_rx_data` in `NB_BYTE`: stream byte.
- `i_rx_valid` in 1: `i_rx_data` valid this cycle; no backpressure.
- `o_preload_flag` out 1: program-memory write strobe.
- `o_preload_address` out `LEN`: word address, zero-extended.
- `o_preload_instruction` out `LEN`: word to write.
- `o_cpu_rst` out 1: held high while the core must stay in reset.
- `o_done` out 1: load completed successfully.
- `o_error` out 1: load aborted.
- `o_word_count` out `$clog2(RAM_DEPTH_PROGRAM)+1`: words written, sentinel included.

## Operation
- States: IDLE, LOAD, CHECK (only with the macro), DONE, ERROR.
- Reset: state goes to LOAD, so loading starts automatically after reset.
  - All data outputs are 0; `o_cpu_rst`=1; `o_done`=`o_error`=0.
  - Byte counter, address and checksum are cleared.
- IDLE: entered only from DONE or ERROR via `i_load_req`; it passes straight to LOAD on the next cycle, clearing counters. `o_cpu_rst`=1.
- LOAD, byte handling:
  - Each `i_rx_valid` byte shifts into the assembly register, MSB-first; the first byte becomes `[LEN-1 -: NB_BYTE]`.
  - Bytes with `i_rx_valid`=0 are ignored.
- LOAD, word completion: after `LEN/NB_BYTE` bytes the word is complete and is written at the current address, then the address increments.
  - Word == `END_WORD`: it is still written (it serves as the halt marker). Go to DONE, or to CHECK if the macro is defined.
  - Word != `END_WORD` at address `RAM_DEPTH_PROGRAM-1`: it is written. The next completed non-sentinel word must not be written; instead go to ERROR (overflow).
  - A sentinel arriving at address `RAM_DEPTH_PROGRAM` is not written; go to DONE (program filled memory exactly).
- DONE: `o_cpu_rst`=0, `o_done`=1. Further bytes are ignored.
- ERROR: `o_cpu_rst`=1, `o_error`=1. Bytes are ignored.
- `i_load_req` in LOAD or CHECK restarts the load: counters clear and memory contents are left as-is. In DONE or ERROR it goes to IDLE.
- `i_rst` overrides everything, including a load mid-word; the partial word is discarded.

## Timing
- Write strobe `o_preload_flag` is one cycle wide, registered, and asserted the cycle after the last byte of a word is accepted.
- Address and instruction are stable during the strobe. The address increments the cycle after the strobe.
- Maximum throughput: one byte per cycle. Back-to-back bytes across word boundaries are never dropped.
- `o_cpu_rst` falls, and `o_done` rises, in the same cycle as the sentinel strobe, or one cycle after the checksum byte with the macro.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined:
  - An `NB_BYTE` running XOR of every byte, sentinel bytes included, is kept.
  - After the sentinel the state enters CHECK. The next valid byte is compared with the running XOR: match goes to DONE, mismatch goes to ERROR.
- Undefined: no CHECK state and no checksum logic; the sentinel goes directly to DONE.

## Structure
- `program_loader_pkg`: state enum, default `END_WORD`, and the width function for `o_word_count`.
- Sub-module `byte_assembler`: shift register plus byte counter with a `word_valid` pulse output; reusable by the data-memory debug path.

## Test plan
- Reset, then stream 8 bytes 8C 01 00 04 / FF FF FF FF → strobe at addr 0 with 8C010004; strobe at addr 1 with FFFFFFFF; `o_done`=1, `o_cpu_rst`=0, `o_word_count`=2.
- Bytes with gaps (`i_rx_valid` toggling 1-0-0-1) → identical writes; no strobe while a word is incomplete.
- 33 non-sentinel words, depth 32 → 32 strobes (addr 0..31); the 33rd word gives no strobe and `o_error`=1 with `o_cpu_rst` held 1.
- `i_rst` after 2 bytes of a word, then a full stream → first write at addr 0 contains only post-reset bytes.
- From DONE, pulse `i_load_req`, then load 1 word plus the sentinel → writes restart at addr 0; `o_done` falls, then rises again.
- Macro defined: sentinel followed by checksum byte 00, then a rerun with byte 5A on a stream whose XOR is 00 → first run reaches DONE, second reaches ERROR.
